// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed driver for a two-digit common-anode 7-segment display.
//   The scan cycles through ONES -> GAP_A -> TENS -> GAP_B. Both digit values
//   are captured into snapshot registers on the edge that enters ONES, so a
//   frame never mixes old and new values. The dark gap slots between the
//   digit slots suppress ghosting.
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   tens  in   [DIGIT_REGS-1:0] BCD tens digit
//   ones  in   [DIGIT_REGS-1:0] BCD ones digit
//   seg   out  [6:0] active-low segments {g,f,e,d,c,b,a}, registered
//   an    out  [3:0] active-low anodes, an[0]=ones, an[1]=tens, registered
module seg_scan_driver #(
  parameter int DIGIT_REGS    = 4,
  parameter int REFRESH_DIV   = 100000,
  parameter int GAP_CYC       = 8,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGIT_REGS-1:0] tens,
  input  logic [DIGIT_REGS-1:0] ones,
  output logic [6:0]            seg,
  output logic [3:0]            an
);

  localparam int MAX_CYC = (REFRESH_DIV > GAP_CYC) ? REFRESH_DIV : GAP_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

  localparam logic [6:0] SEG_DARK = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [3:0] AN_DARK  = 4'b1111;
  localparam logic [3:0] AN_ONES  = 4'b1110;
  localparam logic [3:0] AN_TENS  = 4'b1101;

  typedef enum logic [1:0] {
    S_ONES  = 2'd0,
    S_GAP_A = 2'd1,
    S_TENS  = 2'd2,
    S_GAP_B = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIGIT_REGS-1:0] tens_snap_q, tens_snap_d;
  logic [DIGIT_REGS-1:0] ones_snap_q, ones_snap_d;
  logic [6:0]            seg_q, seg_d;
  logic [3:0]            an_q, an_d;
  logic                  slot_last_s;

  // Active-low BCD decode; anything outside 0..9 (including set upper bits
  // on wide inputs) shows a dash so a bad value is visible, never a digit.
  function automatic logic [6:0] decode(input logic [DIGIT_REGS-1:0] d);
    logic [31:0] dz;
    dz     = 32'(d);
    decode = SEG_DASH;
    if (dz <= 32'd9) begin
      case (dz[3:0])
        4'd0:    decode = 7'b1000000;
        4'd1:    decode = 7'b1111001;
        4'd2:    decode = 7'b0100100;
        4'd3:    decode = 7'b0110000;
        4'd4:    decode = 7'b0011001;
        4'd5:    decode = 7'b0010010;
        4'd6:    decode = 7'b0000010;
        4'd7:    decode = 7'b1111000;
        4'd8:    decode = 7'b0000000;
        4'd9:    decode = 7'b0010000;
        default: decode = SEG_DASH;
      endcase
    end else begin
      decode = SEG_DASH;
    end
  endfunction

  // Next-state, slot counter, snapshot and output computation. Outputs are
  // computed for the state being entered so they change on the same edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    tens_snap_d = tens_snap_q;
    ones_snap_d = ones_snap_q;
    seg_d       = seg_q;
    an_d        = an_q;

    if ((state_q == S_ONES) || (state_q == S_TENS)) begin
      slot_last_s = (cnt_q == REF_LAST);
    end else begin
      slot_last_s = (cnt_q == GAP_LAST);
    end

    if (slot_last_s) begin
      cnt_d = '0;
      case (state_q)
        S_ONES: begin
          state_d = S_GAP_A;
          seg_d   = SEG_DARK;
          an_d    = AN_DARK;
        end
        S_GAP_A: begin
          state_d = S_TENS;
          // Leading-zero blanking darkens the whole tens slot, anode included.
          if ((BLANK_LEADING != 0) && (tens_snap_q == '0)) begin
            seg_d = SEG_DARK;
            an_d  = AN_DARK;
          end else begin
            seg_d = decode(tens_snap_q);
            an_d  = AN_TENS;
          end
        end
        S_TENS: begin
          state_d = S_GAP_B;
          seg_d   = SEG_DARK;
          an_d    = AN_DARK;
        end
        S_GAP_B: begin
          // New frame: capture both digits; ones is shown straight from the
          // captured input so no extra cycle of latency is added.
          state_d     = S_ONES;
          tens_snap_d = tens;
          ones_snap_d = ones;
          seg_d       = decode(ones);
          an_d        = AN_ONES;
        end
        default: begin
          state_d = S_GAP_B;
          seg_d   = SEG_DARK;
          an_d    = AN_DARK;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, counter, snapshot and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_GAP_B;
      cnt_q       <= '0;
      tens_snap_q <= '0;
      ones_snap_q <= '0;
      seg_q       <= SEG_DARK;
      an_q        <= AN_DARK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tens_snap_q <= tens_snap_d;
      ones_snap_q <= ones_snap_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver: two instances (leading-zero blanking on and
// off) share the same stimulus. A frame-position model predicts every
// cycle's outputs; predictions are queued and a monitor compares them.
module tb_seg_scan_driver;

  localparam int R = 4;
  localparam int G = 2;
  localparam int P = 2 * (R + G);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] tens = 4'd0;
  logic [3:0] ones = 4'd0;
  logic [6:0] seg1, seg0;
  logic [3:0] an1, an0;

  seg_scan_driver #(.DIGIT_REGS(4), .REFRESH_DIV(R), .GAP_CYC(G), .BLANK_LEADING(1)) dut1 (
    .clk(clk), .rst(rst), .tens(tens), .ones(ones), .seg(seg1), .an(an1)
  );
  seg_scan_driver #(.DIGIT_REGS(4), .REFRESH_DIV(R), .GAP_CYC(G), .BLANK_LEADING(0)) dut0 (
    .clk(clk), .rst(rst), .tens(tens), .ones(ones), .seg(seg0), .an(an0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg1;
    logic [3:0] an1;
    logic [6:0] seg0;
    logic [3:0] an0;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   age    = 0;
  logic [3:0] snap_t = 4'd0;
  logic [3:0] snap_o = 4'd0;

  function automatic logic [6:0] ref_dec(input int v);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (v > 9) return 7'b0111111;
    return tbl[v];
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, expv);
    end
  endtask

  // Predict the outputs produced by the edge just taken, from the position in
  // the frame counted since the last reset edge.
  task automatic model_edge();
    exp_t e;
    int   ph;
    e.seg1 = 7'b1111111; e.an1 = 4'b1111;
    e.seg0 = 7'b1111111; e.an0 = 4'b1111;
    if (rst) begin
      age = 0;
    end else begin
      age++;
    end
    if (!rst && age >= G) begin
      ph = (age - G) % P;
      if (ph == 0) begin
        snap_t = tens;
        snap_o = ones;
      end
      if (ph < R) begin
        e.seg1 = ref_dec(int'(snap_o)); e.an1 = 4'b1110;
        e.seg0 = ref_dec(int'(snap_o)); e.an0 = 4'b1110;
      end else if (ph >= R + G && ph < 2 * R + G) begin
        e.seg0 = ref_dec(int'(snap_t)); e.an0 = 4'b1101;
        if (snap_t != 4'd0) begin
          e.seg1 = ref_dec(int'(snap_t)); e.an1 = 4'b1101;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic [3:0] t, input logic [3:0] o);
    @(negedge clk);
    rst  = r;
    tens = t;
    ones = o;
    @(posedge clk);
    model_edge();
  endtask

  // Monitor: compare every cycle's outputs against the queued prediction and
  // check that at most one digit anode is low and an[3:2] stay high.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("seg_blank1", seg1, e.seg1);
        check("an_blank1", {3'b000, an1}, {3'b000, e.an1});
        check("seg_blank0", seg0, e.seg0);
        check("an_blank0", {3'b000, an0}, {3'b000, e.an0});
        check("an_onehot1", {5'b00000, (an1[1:0] != 2'b00), an1[3:2] == 2'b11},
              {5'b00000, 1'b1, 1'b1});
        check("an_onehot0", {5'b00000, (an0[1:0] != 2'b00), an0[3:2] == 2'b11},
              {5'b00000, 1'b1, 1'b1});
      end
    end
  end

  initial begin
    // Reset, then tens=5 ones=3.
    for (int i = 0; i < 3; i++) step(1'b1, 4'd5, 4'd3);
    for (int i = 0; i < 26; i++) step(1'b0, 4'd5, 4'd3);
    // tens=0 ones=7 (blanked tens slot on dut1, "0" on dut0).
    for (int i = 0; i < 26; i++) step(1'b0, 4'd0, 4'd7);
    // ones changes 3->4 at varying points inside frames.
    for (int i = 0; i < 10; i++) step(1'b0, 4'd2, 4'd3);
    for (int i = 0; i < 20; i++) step(1'b0, 4'd2, 4'd4);
    // Non-BCD values show a dash.
    for (int i = 0; i < 26; i++) step(1'b0, 4'd12, 4'd15);
    // Reset pulse in the middle of the tens slot: frame position is known
    // from the model age, so wait until mid tens slot.
    begin
      int guard;
      guard = 0;
      while (((age - G) % P) != R + G + 1 && guard < 2 * P) begin
        step(1'b0, 4'd6, 4'd1);
        guard++;
      end
    end
    step(1'b1, 4'd6, 4'd1);
    for (int i = 0; i < 30; i++) step(1'b0, 4'd6, 4'd1);
    // Randomized inputs with occasional reset pulses.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] t, o;
      logic       r;
      t = tens;
      o = ones;
      if ($urandom_range(0, 7) == 0) t = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) o = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 59) == 0);
      step(r, t, o);
    end
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
